tdc_sample_stats: RTL and testbench

- Downstream stage of the TDC sensor tile. Consumes the 8-bit time-count samples the sensor produces.
- Accumulates a fixed window of 2^LOG2_N samples, then publishes the window average.
- With the optional feature compiled in, it also publishes the window minimum and maximum.
- One 8-bit result is selectable at a time through a 2-bit mux select, so it maps directly onto uo_out / ui_in style pins.

---
 rtl/tdc_sample_stats_if.sv | 30 +++
 rtl/tdc_sample_stats.sv | 187 ++++++++++++++++++
 tb/tb_tdc_sample_stats.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_sample_stats_if.sv
// -----------------------------------------------------------------------------
// tdc_sample_stats_if
// Bundles the sample stream, the window control signals and the result pins of
// tdc_sample_stats.
//   master : drives sample_in, sample_valid, start, sel
//            observes result, busy, done, result_valid
//   slave  : the statistics block; the reverse directions
// -----------------------------------------------------------------------------
interface tdc_sample_stats_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              start;
    logic [1:0]        sel;
    logic [DATA_W-1:0] result;
    logic              busy;
    logic              done;
    logic              result_valid;

    modport master (
        output sample_in, sample_valid, start, sel,
        input  result, busy, done, result_valid
    );

    modport slave (
        input  sample_in, sample_valid, start, sel,
        output result, busy, done, result_valid
    );
endinterface

// File: rtl/tdc_sample_stats.sv
// -----------------------------------------------------------------------------
// tdc_sample_stats
// Collects a window of 2^LOG2_N TDC samples and publishes the truncated window
// average. It can optionally also publish the window minimum and maximum.
// Results are selected onto one DATA_W-bit output through bus.sel.
//
// Compile-time option: TDC_STATS_MINMAX_EN builds the min/max tracking. When it
// is undefined, sel=01 and sel=10 read 0.
//
// Ports
//   clk                system clock
//   rst                synchronous, active-high reset
//   bus (slave)        sample_in / sample_valid : sample stream
//                      start                    : begin a window (IDLE/DONE only)
//                      sel                      : 00 avg, 01 min, 10 max, 11 last
//                      result                   : selected result
//                      busy / done / result_valid : status, all registered
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; samples ignored
// ACCUM | accepting samples until the window is full
// DONE  | one-cycle completion pulse; start here chains a new window
// -----------------------------------------------------------------------------
module tdc_sample_stats #(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 4
) (
    input  logic                clk,
    input  logic                rst,
    tdc_sample_stats_if.slave   bus
);
    localparam int ACC_W = DATA_W + LOG2_N;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [LOG2_N-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   avg_q, avg_d;
    logic [DATA_W-1:0]   last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rv_q, rv_d;
    logic [ACC_W-1:0]    sum_full;
    logic                start_win;
    logic                accept;
    logic                final_smp;
`ifdef TDC_STATS_MINMAX_EN
    logic [DATA_W-1:0]   min_q, min_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [DATA_W-1:0]   min_hold_q, min_hold_d;
    logic [DATA_W-1:0]   max_hold_q, max_hold_d;
    logic [DATA_W-1:0]   min_new, max_new;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        avg_d     = avg_q;
        last_d    = last_q;
        rv_d      = rv_q;
        start_win = 1'b0;
        accept    = 1'b0;
        final_smp = 1'b0;
        sum_full  = acc_q + ACC_W'(bus.sample_in);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = ACCUM;
                    start_win = 1'b1;
                end
            end
            ACCUM: begin
                if (bus.sample_valid) begin
                    accept = 1'b1;
                    // Counter is all ones exactly when this is the last sample.
                    final_smp = (cnt_q == {LOG2_N{1'b1}});
                    acc_d  = sum_full;
                    cnt_d  = cnt_q + LOG2_N'(1);
                    last_d = bus.sample_in;
                    if (final_smp) begin
                        avg_d   = sum_full[ACC_W-1:LOG2_N];
                        rv_d    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d   = ACCUM;
                    start_win = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_win) begin
            acc_d = '0;
            cnt_d = '0;
            rv_d  = 1'b0;
        end

        busy_d = (state_d == ACCUM);
        done_d = (state_d == DONE);
    end

`ifdef TDC_STATS_MINMAX_EN
    always_comb begin
        min_new    = (bus.sample_in < min_q) ? bus.sample_in : min_q;
        max_new    = (bus.sample_in > max_q) ? bus.sample_in : max_q;
        min_d      = min_q;
        max_d      = max_q;
        min_hold_d = min_hold_q;
        max_hold_d = max_hold_q;
        if (start_win) begin
            min_d = '1;
            max_d = '0;
        end else if (accept) begin
            min_d = min_new;
            max_d = max_new;
            // Publish including the final sample so the values appear with done.
            if (final_smp) begin
                min_hold_d = min_new;
                max_hold_d = max_new;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            avg_q      <= '0;
            last_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rv_q       <= 1'b0;
`ifdef TDC_STATS_MINMAX_EN
            min_q      <= '0;
            max_q      <= '0;
            min_hold_q <= '0;
            max_hold_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            avg_q      <= avg_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rv_q       <= rv_d;
`ifdef TDC_STATS_MINMAX_EN
            min_q      <= min_d;
            max_q      <= max_d;
            min_hold_q <= min_hold_d;
            max_hold_q <= max_hold_d;
`endif
        end
    end

    always_comb begin
        case (bus.sel)
            2'b00:   bus.result = avg_q;
`ifdef TDC_STATS_MINMAX_EN
            2'b01:   bus.result = min_hold_q;
            2'b10:   bus.result = max_hold_q;
`else
            2'b01:   bus.result = '0;
            2'b10:   bus.result = '0;
`endif
            default: bus.result = last_q;
        endcase
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.result_valid = rv_q;

endmodule

// File: tb/tb_tdc_sample_stats.sv
module tb_tdc_sample_stats;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tdc_sample_stats_if #(.DATA_W(8)) bus();

    tdc_sample_stats #(.DATA_W(8), .LOG2_N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] avg;
        logic [7:0] mn;
        logic [7:0] mx;
        logic [7:0] last;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur = '{8'h00, 8'h00, 8'h00, 8'h00, 0};
    logic [7:0] win [16];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic       prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: window statistics straight from the sample list.
    function automatic exp_t model(input int done_cyc);
        exp_t e;
        int   sum = 0;
        int   mn  = 255;
        int   mx  = 0;
        for (int i = 0; i < 16; i++) begin
            sum += int'(win[i]);
            if (int'(win[i]) < mn) mn = int'(win[i]);
            if (int'(win[i]) > mx) mx = int'(win[i]);
        end
        e.avg  = 8'(sum / 16);
`ifdef TDC_STATS_MINMAX_EN
        e.mn   = 8'(mn);
        e.mx   = 8'(mx);
`else
        e.mn   = 8'h00;
        e.mx   = 8'h00;
`endif
        e.last = win[15];
        e.cyc  = done_cyc;
        return e;
    endfunction

    function automatic logic [7:0] pick(input exp_t e, input logic [1:0] s);
        case (s)
            2'b00:   return e.avg;
            2'b01:   return e.mn;
            2'b10:   return e.mx;
            default: return e.last;
        endcase
    endfunction

    // Monitor: pops the expected window on each done, then checks every
    // cycle in which the DUT claims a valid result.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                chk("done_single_cycle", 32'(prev_done), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected actual=1 expected=0 (t=%0t)", $time);
                end else begin
                    cur = exp_q.pop_front();
                    chk("done_latency_cycle", 32'(cyc), 32'(cur.cyc));
                    chk("done_busy", 32'(bus.busy), 32'd0);
                    chk("done_result_valid", 32'(bus.result_valid), 32'd1);
                end
            end
            if (bus.result_valid)
                chk($sformatf("result_sel%0d", bus.sel), 32'(bus.result), 32'(pick(cur, bus.sel)));
        end
        prev_done = bus.done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The sample presented alongside start must not be counted.
    task automatic begin_window();
        bus.start        = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_in    = 8'($urandom);
        bus.sel          = 2'($urandom_range(0, 3));
        tick();
        bus.start        = 1'b0;
        bus.sample_valid = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("rv_cleared_on_start", 32'(bus.result_valid), 32'd0);
    endtask

    // gap_mode: 0 contiguous, 1 gap between samples (with a start mid-window),
    // 2 random gaps with random start pulses.
    task automatic feed_window(input int gap_mode);
        for (int i = 0; i < 16; i++) begin
            int gaps;
            gaps = (gap_mode == 1) ? ((i == 0) ? 0 : 1)
                 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                bus.sample_valid = 1'b0;
                bus.sample_in    = 8'($urandom);
                bus.start        = (gap_mode == 1) ? (i == 8) : 1'($urandom_range(0, 1));
                tick();
            end
            bus.start        = 1'b0;
            bus.sample_valid = 1'b1;
            bus.sample_in    = win[i];
            if (i == 15) exp_q.push_back(model(cyc + 1));
            tick();
            if (i < 15) chk("busy_in_window", 32'(bus.busy), 32'd1);
        end
        bus.sample_valid = 1'b0;
    endtask

    task automatic sweep_sel();
        for (int s = 0; s < 4; s++) begin
            bus.sel = 2'(s);
            tick();
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.start        = 1'b0;
        bus.sel          = 2'b00;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        for (int s = 0; s < 4; s++) begin
            bus.sel = 2'(s);
            #1;
            chk($sformatf("reset_result_sel%0d", s), 32'(bus.result), 32'd0);
        end
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_rv", 32'(bus.result_valid), 32'd0);
        tick();

        // Constant window
        for (int i = 0; i < 16; i++) win[i] = 8'h40;
        begin_window();
        feed_window(0);
        tick();
        sweep_sel();

        // Ramp with gaps and a mid-window start
        for (int i = 0; i < 16; i++) win[i] = 8'(i);
        begin_window();
        feed_window(1);
        tick();
        sweep_sel();

        // Saturation, then start during DONE
        for (int i = 0; i < 16; i++) win[i] = 8'hFF;
        begin_window();
        feed_window(0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        chk("b2b_rv_cleared", 32'(bus.result_valid), 32'd0);
        for (int i = 0; i < 16; i++) win[i] = 8'($urandom);
        feed_window(2);
        tick();
        sweep_sel();

        // Reset mid-window, start coincident with reset is dropped
        begin_window();
        for (int i = 0; i < 8; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample_in    = 8'h80;
            tick();
        end
        bus.sample_valid = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        tick();
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_rv", 32'(bus.result_valid), 32'd0);
        for (int s = 0; s < 4; s++) begin
            bus.sel = 2'(s);
            #1;
            chk($sformatf("rst_mid_result_sel%0d", s), 32'(bus.result), 32'd0);
        end
        tick();
        for (int i = 0; i < 16; i++) win[i] = 8'h10;
        begin_window();
        feed_window(0);
        tick();
        sweep_sel();

        // Random windows, sometimes chained back to back
        begin_window();
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < 16; i++) win[i] = 8'($urandom);
            feed_window(2);
            if ($urandom_range(0, 1) == 1 && w != 5) begin
                bus.sel   = 2'($urandom_range(0, 3));
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
                chk("rand_b2b_busy", 32'(bus.busy), 32'd1);
            end else begin
                tick();
                sweep_sel();
                if (w != 5) begin_window();
            end
        end

        repeat (3) tick();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
